// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Instruction-memory bus and instruction-delivery handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic                MemReq;
    logic [ADDR_W-1:0]   MemAddr;
    logic                MemAck;
    logic [INSTR_W-1:0]  MemData;

    logic                InstrValid;
    logic [INSTR_W-1:0]  Instr;
    logic [PC_W-1:0]     InstrPC;
    logic                InstrReady;

    modport master (
        output MemReq,
        output MemAddr,
        input  MemAck,
        input  MemData,
        output InstrValid,
        output Instr,
        output InstrPC,
        input  InstrReady
    );

    modport slave (
        input  MemReq,
        input  MemAddr,
        output MemAck,
        output MemData,
        input  InstrValid,
        input  Instr,
        input  InstrPC,
        output InstrReady
    );

endinterface : fetch_ctrl_if

`default_nettype wire

// File: rtl/fetch_pc.sv
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register with load (priority) and increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc
    import fetch_pkg::*;
(
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             load_en,
    input  wire logic [PC_W-1:0]  load_val,
    input  wire logic             inc_en,
    output logic      [PC_W-1:0]  pc
);

    logic [PC_W-1:0] r_pc;

    // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc <= '0;
        end else if (load_en) begin
            r_pc <= load_val;
        end else if (inc_en) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign pc = r_pc;

endmodule : fetch_pc

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller: memory request, hold/handshake,
//               branch redirect and halt-opcode detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
(
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic [PC_W-1:0]  InitVal,
    input  wire logic             Start,
    input  wire logic             Stall,
    input  wire logic             BrTaken,
    input  wire logic [PC_W-1:0]  BrTarget,
    fetch_ctrl_if.master          bus,
    output logic                  Halted,
    output logic      [15:0]      FetchCount
);

    fetch_state_t         r_state;
    logic                 r_outstanding;
    logic                 r_redirect_pending;
    logic [ADDR_W-1:0]    r_req_addr;
    logic                 r_instr_valid;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_instr_pc;
    logic                 r_halted;
    logic [15:0]          r_fetch_count;

    logic [PC_W-1:0]      w_pc;
    logic                 w_pc_load;
    logic [PC_W-1:0]      w_pc_load_val;
    logic                 w_pc_inc;
    logic                 w_mem_req;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic                 w_ack;
    logic                 w_is_halt;

    // A request in flight pins MemReq high and freezes its address, even
    // while a redirect has already moved the PC elsewhere.
    assign w_mem_req  = (r_state == ST_FETCH) && (r_outstanding || !Stall);
    assign w_mem_addr = r_outstanding ? r_req_addr : w_pc[ADDR_W-1:0];
    assign w_ack      = w_mem_req && bus.MemAck;
    assign w_is_halt  = (bus.MemData == HALT_OPCODE);

    always_comb begin
        w_pc_load     = 1'b0;
        w_pc_load_val = InitVal;
        w_pc_inc      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = InitVal;
                end
            end
            ST_FETCH: begin
                if (BrTaken) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = BrTarget;
                end else if (w_ack && !r_redirect_pending && !w_is_halt) begin
                    w_pc_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (BrTaken) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = BrTarget;
                end
            end
            default: ;
        endcase
    end

    fetch_pc u_fetch_pc (
        .Clk      (Clk),
        .Reset    (Reset),
        .load_en  (w_pc_load),
        .load_val (w_pc_load_val),
        .inc_en   (w_pc_inc),
        .pc       (w_pc)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state            <= ST_IDLE;
            r_outstanding      <= 1'b0;
            r_redirect_pending <= 1'b0;
            r_req_addr         <= '0;
            r_instr_valid      <= 1'b0;
            r_instr            <= '0;
            r_instr_pc         <= '0;
            r_halted           <= 1'b0;
            r_fetch_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (Start) begin
                        r_state            <= ST_FETCH;
                        r_fetch_count      <= '0;
                        r_halted           <= 1'b0;
                        r_outstanding      <= 1'b0;
                        r_redirect_pending <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (BrTaken) begin
                        // Redirect wins; a word still owed by memory is tagged stale.
                        if (w_mem_req && !bus.MemAck) begin
                            r_outstanding      <= 1'b1;
                            r_req_addr         <= w_mem_addr;
                            r_redirect_pending <= 1'b1;
                        end else if (w_ack) begin
                            r_outstanding      <= 1'b0;
                            r_redirect_pending <= 1'b0;
                        end
                    end else if (w_ack) begin
                        r_outstanding <= 1'b0;
                        if (r_redirect_pending) begin
                            r_redirect_pending <= 1'b0;
                        end else if (w_is_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_instr       <= bus.MemData;
                            r_instr_pc    <= w_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end else if (w_mem_req) begin
                        r_outstanding <= 1'b1;
                        r_req_addr    <= w_mem_addr;
                    end
                end

                ST_HOLD: begin
                    if (BrTaken) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_FETCH;
                    end else if (bus.InstrReady) begin
                        r_instr_valid <= 1'b0;
                        r_fetch_count <= r_fetch_count + 16'd1;
                        r_state       <= ST_FETCH;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.MemReq     = w_mem_req;
    assign bus.MemAddr    = w_mem_addr;
    assign bus.InstrValid = r_instr_valid;
    assign bus.Instr      = r_instr;
    assign bus.InstrPC    = r_instr_pc;
    assign Halted         = r_halted;
    assign FetchCount     = r_fetch_count;

endmodule : fetch_ctrl

`default_nettype wire
